// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI slave datapaths.
package spi_pkg;

  localparam int SPI_BYTE_W    = 8;
  localparam int SPI_BIT_CNT_W = 3;

  localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE_DEF = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser for an asynchronous SPI pin plus single-cycle rise/fall pulses.
// Edge-to-pulse latency is SYNC_STAGES clk; a consumer registering on the
// pulse sees the edge SYNC_STAGES+1 clk after it happened. SYNC_STAGES must be >= 2.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // All stages reset to 0: a CS_n still held low across reset produces no
  // fall, so the slave stays deselected until the master reselects it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign o_fall = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter (MISO) with a 1-entry holding buffer.
// Build option: SPI_SLAVE_TX_LSB_FIRST_EN shifts bytes out LSB first
// (default MSB first); timing, handshake and pulses are unchanged.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = SPI_IDLE_BYTE_DEF,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_spi_sck,
  input  logic                  i_spi_cs_n,
  output logic                  o_spi_miso,
  output logic                  o_spi_miso_en,
  input  logic                  i_tx_valid,
  input  logic [SPI_BYTE_W-1:0] i_tx_data,
  output logic                  o_tx_ready,
  output logic                  o_tx_done,
  output logic                  o_tx_underrun
);

`ifdef SPI_SLAVE_TX_LSB_FIRST_EN
  localparam int TX_BIT = 0;
`else
  localparam int TX_BIT = SPI_BYTE_W - 1;
`endif

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst(rst), .i_async(i_spi_sck), .o_rise(sck_rise), .o_fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .i_async(i_spi_cs_n), .o_rise(cs_rise), .o_fall(cs_fall)
  );

  spi_state_e                 state_q;
  logic [SPI_BIT_CNT_W-1:0]   bit_cnt_q;
  logic [SPI_BYTE_W-1:0]      sh_q;
  logic [SPI_BYTE_W-1:0]      hold_data_q;
  logic                       hold_valid_q;
  logic                       miso_en_q;
  logic                       done_q;
  logic                       underrun_q;

  logic                       accept;
  logic                       reload_req;
  logic [SPI_BYTE_W-1:0]      reload_byte;
  logic [SPI_BYTE_W-1:0]      shifted;

  assign o_tx_ready = ~hold_valid_q & ~rst;
  assign accept     = i_tx_valid & o_tx_ready;

  // Byte-boundary reload request and the shift-register candidates.
  always_comb begin
    reload_req  = 1'b0;
    reload_byte = hold_valid_q ? hold_data_q : IDLE_BYTE;
`ifdef SPI_SLAVE_TX_LSB_FIRST_EN
    shifted     = {1'b0, sh_q[SPI_BYTE_W-1:1]};
`else
    shifted     = {sh_q[SPI_BYTE_W-2:0], 1'b0};
`endif
    if (state_q == ST_IDLE) begin
      reload_req = cs_fall;
    end else begin
      // CS_n rise masks any SCK edge seen in the same cycle.
      reload_req = ~cs_rise & ~sck_rise & sck_fall & (bit_cnt_q == '0);
    end
  end

  // Holding buffer: fill on accept, drain on a reload. Accept only happens
  // when empty and a reload only drains when full, so the two never collide;
  // a byte accepted during an empty-buffer reload waits for the next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else if (accept) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= i_tx_data;
    end else if (reload_req) begin
      hold_valid_q <= 1'b0;
    end
  end

  // Transmit FSM with registered MISO, enable and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      miso_en_q  <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      if (reload_req) begin
        sh_q       <= reload_byte;
        underrun_q <= ~hold_valid_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q   <= ST_SHIFT;
            bit_cnt_q <= '0;
            miso_en_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            miso_en_q <= 1'b0;
            sh_q      <= '0;
          end else if (sck_rise) begin
            bit_cnt_q <= bit_cnt_q + SPI_BIT_CNT_W'(1);
            done_q    <= (bit_cnt_q == '1);
          end else if (sck_fall && (bit_cnt_q != '0)) begin
            sh_q <= shifted;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // sh_q is cleared while deselected, so MISO reads 0 outside a transfer.
  assign o_spi_miso    = sh_q[TX_BIT];
  assign o_spi_miso_en = miso_en_q;
  assign o_tx_done     = done_q;
  assign o_tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Self-checking bench for spi_slave_tx: SPI mode-0 master model, expected
// bytes queued when stimulus is driven and compared as the master receives.
module tb_spi_slave_tx;

  localparam int HALF = 5;  // clk cycles per SCK half period (5 MHz SCK)

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       cs_n;
  logic       miso;
  logic       miso_en;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_underrun;

  always #10 clk = ~clk;

  spi_slave_tx dut (
    .clk           (clk),
    .rst           (rst),
    .i_spi_sck     (sck),
    .i_spi_cs_n    (cs_n),
    .o_spi_miso    (miso),
    .o_spi_miso_en (miso_en),
    .i_tx_valid    (tx_valid),
    .i_tx_data     (tx_data),
    .o_tx_ready    (tx_ready),
    .o_tx_done     (tx_done),
    .o_tx_underrun (tx_underrun)
  );

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         und_cnt = 0;
  logic       en_bad;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_done)     done_cnt++;
      if (tx_underrun) und_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_sb(input logic [7:0] rx);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got %0h expected nothing", rx);
    end else begin
      check("miso_byte", {24'h0, rx}, {24'h0, exp_q.pop_front()});
    end
  endtask

  task automatic load(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("load_timeout", 32'd0, 32'd1);
    end else begin
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  task automatic sck_bit(output logic b);
    repeat (HALF) @(negedge clk);
    b = miso;
    if (miso_en !== 1'b1) en_bad = 1'b1;
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  // Receive one byte; optionally offer a byte to the fabric port after bit load_at.
  task automatic rx_byte(input int load_at, input logic [7:0] load_d);
    logic [7:0] rx = '0;
    logic       b;
    for (int i = 0; i < 8; i++) begin
      sck_bit(b);
`ifdef SPI_SLAVE_TX_LSB_FIRST_EN
      rx = {b, rx[7:1]};
`else
      rx = {rx[6:0], b};
`endif
      if (i == load_at) load(load_d);
    end
    check_sb(rx);
  endtask

  task automatic select();
    @(negedge clk);
    cs_n   = 1'b0;
    en_bad = 1'b0;
  endtask

  task automatic deselect();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic       preload;
    logic [7:0] data;
    logic [7:0] exp_byte;
    int         exp_und;   // includes the empty-buffer reload on the trailing SCK fall
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, u0;
    logic b;

    vecs[0] = '{1'b1, 8'hA5, 8'hA5, 1};
    vecs[1] = '{1'b1, 8'h3C, 8'h3C, 1};
    vecs[2] = '{1'b0, 8'h00, 8'hFF, 2};
    vecs[3] = '{1'b1, 8'h00, 8'h00, 1};
    vecs[4] = '{1'b1, 8'h81, 8'h81, 1};

    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; tx_valid = 1'b0; tx_data = '0; en_bad = 1'b0;

    // T1: outputs held at 0 through reset, ready as soon as reset drops.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {27'h0, miso, miso_en, tx_done, tx_underrun, tx_ready}, 32'h0);
    end
    rst = 1'b0;
    #1;
    check("ready_after_reset", {31'h0, tx_ready}, 32'h1);
    repeat (6) @(negedge clk);
    check("idle_miso_en", {31'h0, miso_en}, 32'h0);

    // Table: single-byte frames.
    foreach (vecs[k]) begin
      d0 = done_cnt; u0 = und_cnt;
      if (vecs[k].preload) load(vecs[k].data);
      exp_q.push_back(vecs[k].exp_byte);
      select();
      rx_byte(-1, 8'h00);
      check("ready_in_frame", {31'h0, tx_ready}, 32'h1);
      deselect();
      check("done_count",     done_cnt - d0, 32'd1);
      check("underrun_count", und_cnt - u0, vecs[k].exp_und);
      check("miso_en_during", {31'h0, en_bad}, 32'h0);
      check("miso_en_after",  {31'h0, miso_en}, 32'h0);
    end

    // T3: empty select -> idle byte; byte loaded mid-frame goes out next with no boundary underrun.
    d0 = done_cnt; u0 = und_cnt;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    select();
    rx_byte(3, 8'h3C);
    check("t3_underrun_first", und_cnt - u0, 32'd1);
    rx_byte(-1, 8'h00);
    deselect();
    check("t3_underrun_total", und_cnt - u0, 32'd2);
    check("t3_done_count",     done_cnt - d0, 32'd2);

    // T4: back-to-back bytes with refill once the first is consumed.
    d0 = done_cnt; u0 = und_cnt;
    load(8'h01);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    select();
    rx_byte(0, 8'h80);
    rx_byte(-1, 8'h00);
    deselect();
    check("t4_done_count",     done_cnt - d0, 32'd2);
    check("t4_underrun_count", und_cnt - u0, 32'd1);

    // T5: abort after 3 SCK; preloaded next byte survives and goes first on reselect.
    d0 = done_cnt;
    load(8'hB1);
    select();
    for (int i = 0; i < 3; i++) sck_bit(b);
    load(8'h22);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_miso_en_off", {30'h0, miso_en, miso}, 32'h0);
    check("t5_ready_kept",  {31'h0, tx_ready}, 32'h0);
    repeat (8) @(negedge clk);
    check("t5_no_done", done_cnt - d0, 32'd0);
    exp_q.push_back(8'h22);
    select();
    rx_byte(-1, 8'h00);
    deselect();
    check("t5_done_reselect", done_cnt - d0, 32'd1);

    // Reset mid-transfer: back to reset values, no reselect while CS_n stays low.
    load(8'h5A);
    select();
    for (int i = 0; i < 2; i++) sck_bit(b);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {29'h0, miso, miso_en, tx_ready}, 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_stay_idle", {30'h0, miso_en, miso}, 32'h0);
    check("rst_buffer_empty", {31'h0, tx_ready}, 32'h1);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
